// File: rtl/pong_pkg.sv
// Shared types and constants for the pong match sequencer.
// Holds the FSM state enum, score width and a saturating score helper.
package pong_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    SERVE     = 3'd1,
    RALLY     = 3'd2,
    POINT     = 3'd3,
    GAME_OVER = 3'd4
  } game_state_t;

  localparam int SCORE_W     = 4;
  localparam int WIN_SCORE_D = 9;

  function automatic logic [SCORE_W-1:0] sat_inc(
    input logic [SCORE_W-1:0] s,
    input logic [SCORE_W-1:0] lim
  );
    return (s >= lim) ? lim : s + 1'b1;
  endfunction

endpackage

// File: rtl/pong_game_ctrl_if.sv
// Match-control bundle between the ball/paddle side and the score display.
// master drives tick/serve/score levels; slave is the sequencer.
interface pong_game_ctrl_if;
  import pong_pkg::*;

  logic               tick;
  logic               serve_btn;
  logic               score_left;
  logic               score_right;
  logic               ball_run;
  logic               ball_recenter;
  logic               serve_right;
  logic [SCORE_W-1:0] left_score;
  logic [SCORE_W-1:0] right_score;
  logic               game_over;
  logic               left_wins;
  logic [2:0]         state_o;

  modport master (
    output tick, serve_btn,
    output score_left, score_right,
    input  ball_run, ball_recenter,
    input  serve_right, left_score,
    input  right_score, game_over,
    input  left_wins, state_o
  );

  modport slave (
    input  tick, serve_btn,
    input  score_left, score_right,
    output ball_run, ball_recenter,
    output serve_right, left_score,
    output right_score, game_over,
    output left_wins, state_o
  );

endinterface

// File: rtl/pong_edge_det.sv
// Rising-edge pulse generator with optional 2-flop synchroniser.
// Ports: clk, reset (sync, active-low), d level in, pulse 1-cycle out.
module pong_edge_det #(
  parameter bit SYNC = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic pulse
);

  logic s1;
  logic s2;
  logic prev;
  logic cur;

  assign cur   = SYNC ? s2 : d;
  assign pulse = cur & ~prev;

  always_ff @(posedge clk) begin
    if (!reset) begin
      s1   <= 1'b0;
      s2   <= 1'b0;
      prev <= 1'b0;
    end else begin
      s1   <= d;
      s2   <= s1;
      prev <= cur;
    end
  end

endmodule

// File: rtl/pong_game_ctrl.sv
// Pong match sequencer: serve/rally/point/game-over flow, scores, serve dir.
// Ports: clk, reset (sync, active-low), bus (pong_game_ctrl_if.slave).
module pong_game_ctrl
  import pong_pkg::*;
#(
  parameter int WIN_SCORE   = WIN_SCORE_D,
  parameter int SERVE_TICKS = 60,
  parameter int POINT_TICKS = 30,
  parameter int CNT_W       = 8
) (
  input logic               clk,
  input logic               reset,
  pong_game_ctrl_if.slave   bus
);

  localparam logic [SCORE_W-1:0] WIN =
    SCORE_W'(WIN_SCORE);
  localparam logic [CNT_W-1:0] SRV_N =
    CNT_W'(SERVE_TICKS);
  localparam logic [CNT_W-1:0] PNT_N =
    CNT_W'(POINT_TICKS);

  logic serve_req;
  logic pt_l;
  logic pt_r;

  pong_edge_det #(.SYNC(1'b1)) u_srv (
    .clk   (clk),
    .reset (reset),
    .d     (bus.serve_btn),
    .pulse (serve_req)
  );

  pong_edge_det #(.SYNC(1'b0)) u_pl (
    .clk   (clk),
    .reset (reset),
    .d     (bus.score_left),
    .pulse (pt_l)
  );

  pong_edge_det #(.SYNC(1'b0)) u_pr (
    .clk   (clk),
    .reset (reset),
    .d     (bus.score_right),
    .pulse (pt_r)
  );

  game_state_t        state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [SCORE_W-1:0] ls_q, ls_d;
  logic [SCORE_W-1:0] rs_q, rs_d;
  logic               sr_q, sr_d;
  logic               lw_q, lw_d;
  logic               run_q, run_d;
  logic               rec_q, rec_d;
  logic               go_q, go_d;
  logic               expire;
  logic [SCORE_W-1:0] scorer;

  // Counter at 1 or 0 on a tick ends the wait.
  assign expire = (cnt_q <= CNT_W'(1));
  // serve_right=1 means left took the last point.
  assign scorer = sr_q ? ls_q : rs_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ls_q    <= '0;
      rs_q    <= '0;
      sr_q    <= 1'b1;
      lw_q    <= 1'b0;
      run_q   <= 1'b0;
      rec_q   <= 1'b1;
      go_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ls_q    <= ls_d;
      rs_q    <= rs_d;
      sr_q    <= sr_d;
      lw_q    <= lw_d;
      run_q   <= run_d;
      rec_q   <= rec_d;
      go_q    <= go_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ls_d    = ls_q;
    rs_d    = rs_q;
    sr_d    = sr_q;
    lw_d    = lw_q;
    unique case (state_q)
      IDLE: begin
        if (serve_req) begin
          state_d = SERVE;
          cnt_d   = SRV_N;
        end
      end
      SERVE: begin
        if (bus.tick) begin
          if (expire) begin
            state_d = RALLY;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
      end
      RALLY: begin
        if (pt_l) begin
          ls_d    = sat_inc(ls_q, WIN);
          sr_d    = 1'b1;
          state_d = POINT;
          cnt_d   = PNT_N;
        end else if (pt_r) begin
          rs_d    = sat_inc(rs_q, WIN);
          sr_d    = 1'b0;
          state_d = POINT;
          cnt_d   = PNT_N;
        end
      end
      POINT: begin
        if (bus.tick) begin
          if (!expire) begin
            cnt_d = cnt_q - 1'b1;
          end else if (scorer == WIN) begin
            state_d = GAME_OVER;
            lw_d    = sr_q;
            cnt_d   = '0;
          end else begin
            state_d = SERVE;
            cnt_d   = SRV_N;
          end
        end
      end
      GAME_OVER: begin
        if (serve_req) begin
          ls_d    = '0;
          rs_d    = '0;
          state_d = SERVE;
          cnt_d   = SRV_N;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Outputs follow the next state so they land with it.
  always_comb begin
    run_d = (state_d == RALLY);
    rec_d = (state_d != RALLY);
    go_d  = (state_d == GAME_OVER);
  end

  assign bus.ball_run      = run_q;
  assign bus.ball_recenter = rec_q;
  assign bus.serve_right   = sr_q;
  assign bus.left_score    = ls_q;
  assign bus.right_score   = rs_q;
  assign bus.game_over     = go_q;
  assign bus.left_wins     = lw_q;
  assign bus.state_o       = state_q;

endmodule
